timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter.sv | 184 ++++++++++++++++++
 tb/tb_timer_counter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// TimerCounter -- memory-mapped down-counting timer with interrupt
//
// A small bus-attached timer. Software loads a PRESET value and enables the
// timer through CTRL. The timer then copies PRESET into COUNT and counts
// down once per clock. When COUNT runs out, an internal flag is raised.
//
// The mode bits in CTRL decide what happens next:
//   - One-shot (mode 0): the timer disables itself. The flag stays set until
//     software writes CTRL.
//   - Auto-reload (mode 1): the flag is pulsed for one cycle. The timer then
//     restarts from PRESET.
//
// Register map (only addr_i[3:2] is decoded; the bridge does range decode):
//   0  CTRL    [3:0]  bit0 EN, bits[2:1] MODE, bit3 IM (irq mask, 1=enable)
//   1  PRESET  [31:0] reload value
//   2  COUNT   [31:0] current count, read-only
//   3  --      reads 0, writes ignored
//
// Ports:
//   clk_i      single clock, all state changes on the rising edge
//   reset_n_i  asynchronous active-low reset
//   addr_i     byte address from the system bridge
//   we_i       write strobe for this timer
//   wdata_i    store data
//   rdata_o    combinational read data selected by addr_i[3:2]
//   irq_o      interrupt request (flag AND IM)
//
// Parameter:
//   MODE1_EN   when 0, auto-reload mode behaves exactly like one-shot
// ---------------------------------------------------------------------------
module timer_counter #(
    parameter bit MODE1_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    // Register select values for addr_i[3:2]
    localparam logic [1:0] SelCtrl   = 2'd0;
    localparam logic [1:0] SelPreset = 2'd1;
    localparam logic [1:0] SelCount  = 2'd2;

    // Timer sequencing states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic [1:0]  regSel;
    logic        ctrlEn;
    logic        ctrlIm;
    logic        autoReload;
    logic        unusedAddrBits;

    assign regSel = addr_i[3:2];
    assign ctrlEn = ctrl_q[0];
    assign ctrlIm = ctrl_q[3];

    // MODE values 2 and 3 fall back to one-shot. Auto-reload can also be
    // compiled out through MODE1_EN.
    assign autoReload = MODE1_EN && (ctrl_q[2:1] == 2'b01);

    // The bridge already did range decode, so the remaining address bits
    // carry no information for this block.
    assign unusedAddrBits = ^{addr_i[31:4], addr_i[1:0]};

    // Next-state logic.
    //
    // A bus write wins over timer progress. In a write cycle only the
    // addressed register changes, and the FSM and COUNT stand still.
    //
    // Writing CTRL always clears the flag. This gives software a single
    // store that both acknowledges the interrupt and reprograms the timer.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        if (we_i) begin
            case (regSel)
                SelCtrl: begin
                    ctrl_d = wdata_i[3:0];
                    flag_d = 1'b0;
                end
                SelPreset: begin
                    preset_d = wdata_i;
                end
                default: begin
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrlEn) begin
                        state_d = S_LOAD;
                    end
                end

                S_LOAD: begin
                    count_d = preset_q;
                    state_d = S_CNT;
                end

                // A COUNT of 0 or 1 both finish in this cycle. A PRESET of
                // 0 therefore acts like 1, and COUNT never wraps below zero.
                S_CNT: begin
                    if (!ctrlEn) begin
                        state_d = S_IDLE;
                    end else if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        count_d = 32'd0;
                        flag_d  = 1'b1;
                        state_d = S_INT;
                    end
                end

                // One-shot disables itself and keeps the flag for software.
                // Auto-reload drops the flag so irq is a single-cycle pulse,
                // and goes round again through LOAD.
                S_INT: begin
                    if (autoReload) begin
                        flag_d = 1'b0;
                    end else begin
                        ctrl_d[0] = 1'b0;
                    end
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and register storage, cleared asynchronously by reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // Read mux, purely combinational so a load sees the value in the same
    // cycle
    always_comb begin
        rdata_o = 32'd0;
        case (regSel)
            SelCtrl:   rdata_o = {28'd0, ctrl_q};
            SelPreset: rdata_o = preset_q;
            SelCount:  rdata_o = count_q;
            default:   rdata_o = 32'd0;
        endcase
    end

    assign irq_o = flag_q & ctrlIm;

endmodule

// File: tb/tb_timer_counter.sv
// ---------------------------------------------------------------------------
// tb_timer_counter -- self-checking bench for TimerCounter
//
// Runs directed scenarios first, then a stretch of random bus traffic.
//
// A behavioural model of the timer runs alongside the DUT. The model is
// described as a sequence of phases:
//   1. waiting for enable
//   2. one cycle to load PRESET
//   3. counting down
//   4. one wrap-up cycle after expiry
//
// Inputs change 2ns after the rising edge. Outputs are sampled at that
// same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_timer_counter;

    logic        clk;
    logic        resetN;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0]  mCtrl;
    logic [31:0] mPreset;
    logic [31:0] mCount;
    logic        mFlag;
    int          mPhase;

    timer_counter #(.MODE1_EN(1'b1)) dut (
        .clk_i    (clk),
        .reset_n_i(resetN),
        .addr_i   (addr),
        .we_i     (we),
        .wdata_i  (wdata),
        .rdata_o  (rdata),
        .irq_o    (irq)
    );

    // 10ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point. Counts every check and every failure.
    task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected read data for a given register select
    function automatic logic [31:0] modelRead(input logic [1:0] sel);
        case (sel)
            2'd0:    return {28'd0, mCtrl};
            2'd1:    return mPreset;
            2'd2:    return mCount;
            default: return 32'd0;
        endcase
    endfunction

    // Advances the model across one rising edge, using the current inputs.
    //
    // Phases: 0 = waiting for enable, 1 = loading PRESET, 2 = counting,
    // 3 = wrap-up after expiry.
    task automatic modelEdge();
        if (we) begin
            if (addr[3:2] == 2'd0) begin
                mCtrl = wdata[3:0];
                mFlag = 1'b0;
            end else if (addr[3:2] == 2'd1) begin
                mPreset = wdata;
            end
        end else begin
            case (mPhase)
                0: if (mCtrl[0]) mPhase = 1;
                1: begin
                    mCount = mPreset;
                    mPhase = 2;
                end
                2: begin
                    if (!mCtrl[0]) begin
                        mPhase = 0;
                    end else if (mCount > 1) begin
                        mCount = mCount - 1;
                    end else begin
                        mCount = 0;
                        mFlag  = 1'b1;
                        mPhase = 3;
                    end
                end
                default: begin
                    if (mCtrl[2:1] == 2'd1) mFlag = 1'b0;
                    else mCtrl[0] = 1'b0;
                    mPhase = 0;
                end
            endcase
        end
    endtask

    // Compares irq and the read data at the current address against the model
    task automatic checkOutput(input string tag);
        expectEq({tag, ".irq"}, {31'd0, irq}, {31'd0, mFlag & mCtrl[3]});
        expectEq({tag, ".rdata"}, rdata, modelRead(addr[3:2]));
    endtask

    // Places a register select on the bus. The upper and lower address bits
    // are filled with noise, since only bits [3:2] are decoded.
    task automatic setAddr(input logic [1:0] sel);
        addr = ($urandom & 32'hFFFF_FFF0) | {28'd0, sel, 2'b00} | ($urandom & 32'h3);
    endtask

    // Runs one clock edge, then checks the outputs against the model
    task automatic applyStimulus(input string tag);
        modelEdge();
        @(posedge clk);
        #2;
        checkOutput(tag);
    endtask

    // One bus write cycle
    task automatic writeReg(input logic [1:0] sel, input logic [31:0] data);
        setAddr(sel);
        we    = 1'b1;
        wdata = data;
        applyStimulus("write");
        we    = 1'b0;
        wdata = $urandom;
    endtask

    // One cycle with no write, reading the given register
    task automatic idleAt(input logic [1:0] sel);
        setAddr(sel);
        we = 1'b0;
        applyStimulus("idle");
    endtask

    // Reads a register without a clock edge and compares it with a constant
    task automatic readAt(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        setAddr(sel);
        we = 1'b0;
        #1;
        expectEq(tag, rdata, exp);
        expectEq({tag, ".model"}, rdata, modelRead(sel));
    endtask

    // Holds reset across two edges and clears the model to match
    task automatic doReset();
        resetN  = 1'b0;
        mCtrl   = 4'd0;
        mPreset = 32'd0;
        mCount  = 32'd0;
        mFlag   = 1'b0;
        mPhase  = 0;
        repeat (2) @(posedge clk);
        #2;
        resetN = 1'b1;
    endtask

    initial begin
        we    = 1'b0;
        wdata = 32'd0;
        addr  = 32'd0;
        doReset();

        // Reset state
        readAt("rst.ctrl", 2'd0, 32'd0);
        readAt("rst.preset", 2'd1, 32'd0);
        readAt("rst.count", 2'd2, 32'd0);
        expectEq("rst.irq", {31'd0, irq}, 32'd0);

        // One-shot, PRESET=5. The CTRL write is edge E0.
        writeReg(2'd1, 32'd5);
        writeReg(2'd0, 32'h9);
        repeat (2) idleAt(2'd2);
        expectEq("os.count5", rdata, 32'd5);
        repeat (4) idleAt(2'd2);
        expectEq("os.count1", rdata, 32'd1);
        expectEq("os.irq_lo", {31'd0, irq}, 32'd0);
        idleAt(2'd2);
        expectEq("os.count0", rdata, 32'd0);
        expectEq("os.irq_hi", {31'd0, irq}, 32'd1);
        idleAt(2'd0);
        expectEq("os.ctrl8", rdata, 32'h8);
        repeat (3) idleAt(2'd2);
        expectEq("os.irq_held", {31'd0, irq}, 32'd1);

        // Writing CTRL acknowledges the interrupt
        writeReg(2'd0, 32'h0);
        expectEq("ack.irq", {31'd0, irq}, 32'd0);
        readAt("ack.count", 2'd2, 32'd0);

        // Auto-reload, PRESET=3: one-cycle irq every 6 cycles starting E0+5
        writeReg(2'd1, 32'd3);
        writeReg(2'd0, 32'hB);
        for (int k = 1; k <= 20; k++) begin
            idleAt(2'd0);
            expectEq($sformatf("ar.irq%0d", k), {31'd0, irq},
                     (k >= 5 && ((k - 5) % 6) == 0) ? 32'd1 : 32'd0);
        end
        expectEq("ar.en", {31'd0, rdata[0]}, 32'd1);
        writeReg(2'd0, 32'h0);
        repeat (4) idleAt(2'd2);

        // PRESET=0 with IM=0: flag is set at E3 but irq stays low
        writeReg(2'd1, 32'd0);
        writeReg(2'd0, 32'h1);
        repeat (3) idleAt(2'd2);
        expectEq("p0.irq", {31'd0, irq}, 32'd0);
        expectEq("p0.count", rdata, 32'd0);
        idleAt(2'd0);
        expectEq("p0.ctrl", rdata, 32'd0);

        // Pausing mid-count freezes COUNT; re-enabling reloads PRESET
        writeReg(2'd1, 32'd10);
        writeReg(2'd0, 32'h1);
        repeat (6) idleAt(2'd2);
        expectEq("pz.count6", rdata, 32'd6);
        writeReg(2'd0, 32'h0);
        repeat (3) idleAt(2'd2);
        expectEq("pz.hold6", rdata, 32'd6);
        writeReg(2'd0, 32'h1);
        idleAt(2'd2);
        expectEq("pz.still6", rdata, 32'd6);
        idleAt(2'd2);
        expectEq("pz.reload", rdata, 32'd10);
        repeat (2) idleAt(2'd2);

        // A PRESET write mid-count leaves the running COUNT alone
        writeReg(2'd1, 32'd2);
        readAt("pw.count", 2'd2, 32'd8);
        idleAt(2'd2);
        expectEq("pw.dec", rdata, 32'd7);
        writeReg(2'd0, 32'h0);
        repeat (3) idleAt(2'd2);

        // Asynchronous reset in the middle of a count
        writeReg(2'd1, 32'd20);
        writeReg(2'd0, 32'h9);
        repeat (5) idleAt(2'd2);
        expectEq("ar.pre", rdata, 32'd17);
        resetN  = 1'b0;
        mCtrl   = 4'd0;
        mPreset = 32'd0;
        mCount  = 32'd0;
        mFlag   = 1'b0;
        mPhase  = 0;
        readAt("arst.count", 2'd2, 32'd0);
        readAt("arst.ctrl", 2'd0, 32'd0);
        readAt("arst.preset", 2'd1, 32'd0);
        expectEq("arst.irq", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #2;
        resetN = 1'b1;

        // Writes to COUNT and to the unused slot change nothing
        writeReg(2'd3, 32'hDEAD_BEEF);
        writeReg(2'd2, 32'h1234_5678);
        readAt("ro.slot3", 2'd3, 32'd0);
        readAt("ro.count", 2'd2, 32'd0);
        readAt("ro.ctrl", 2'd0, 32'd0);
        readAt("ro.preset", 2'd1, 32'd0);
        repeat (3) idleAt(2'd2);
        expectEq("ro.idle", rdata, 32'd0);

        // Random bus traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0) writeReg(2'd1, 32'($urandom_range(0, 6)));
            else if (r == 1) writeReg(2'd0, 32'($urandom_range(0, 15)));
            else if (r == 2) writeReg(2'($urandom_range(2, 3)), $urandom);
            else idleAt(2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
